// File: rtl/csa_block_serial_subtractor.sv
// Block-serial subtractor: D = A - B - Bin, one BLOCK_SIZE slice per clock.
// Both borrow speculations are formed per slice and the running carry picks one.
module csa_block_serial_subtractor #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BLOCK_SIZE = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic                  Bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] D,
  output logic                  Bout,
  output logic                  OVF
);

  localparam int unsigned Stages = DATA_WIDTH / BLOCK_SIZE;
  localparam int unsigned IdxW   = (Stages > 1) ? $clog2(Stages) : 1;
  localparam int unsigned Msb    = DATA_WIDTH - 1;

  if (DATA_WIDTH % BLOCK_SIZE != 0) begin : gen_width_check
    $error("DATA_WIDTH must be a multiple of BLOCK_SIZE");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                state_q;
  logic [IdxW-1:0]       idx_q;
  logic [DATA_WIDTH-1:0] a_q, b_q, d_q;
  logic                  carry_q, bout_q, ovf_q, out_valid_q;

  logic [31:0]           base;
  logic [BLOCK_SIZE-1:0] a_k, b_k;
  logic [BLOCK_SIZE:0]   s0, s1, sel;
  logic                  last;

  // Subtraction as A + ~B + carry, where carry is the inverted running borrow.
  always_comb begin
    base = 32'(idx_q) * BLOCK_SIZE;
    a_k  = a_q[base +: BLOCK_SIZE];
    b_k  = b_q[base +: BLOCK_SIZE];
    s0   = {1'b0, a_k} + {1'b0, ~b_k};
    s1   = {1'b0, a_k} + {1'b0, ~b_k} + (BLOCK_SIZE + 1)'(1);
    sel  = carry_q ? s1 : s0;
    last = (idx_q == IdxW'(Stages - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      d_q         <= '0;
      carry_q     <= 1'b0;
      bout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q     <= A;
            b_q     <= B;
            carry_q <= ~Bin;
            d_q     <= '0;
            idx_q   <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          d_q[base +: BLOCK_SIZE] <= sel[BLOCK_SIZE-1:0];
          carry_q                 <= sel[BLOCK_SIZE];
          idx_q                   <= idx_q + IdxW'(1);
          if (last) begin
            bout_q      <= ~sel[BLOCK_SIZE];
            // The last slice's top bit is the msb of the final difference.
            ovf_q       <= (a_q[Msb] != b_q[Msb]) && (sel[BLOCK_SIZE-1] != a_q[Msb]);
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = out_valid_q;
  assign D         = d_q;
  assign Bout      = bout_q;
  assign OVF       = ovf_q;

endmodule
